// File: rtl/alu_pkg.sv
// Shared ALU op encoding, sequencer states and small helpers for the datapath ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } seq_alu_state_e;

    function automatic logic is_shift(alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops; shifts are handled by the iterator in seq_alu.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    alu_op_e op_e;
    assign op_e = alu_op_e'(op);

    always_comb begin
        y = '0;
        case (op_e)
            ALU_SUB:  y = a - b;
            ALU_SLT:  y[0] = $signed(a) < $signed(b);
            ALU_SLTU: y[0] = a < b;
            ALU_XOR:  y = a ^ b;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            // ADD and every unassigned code (shift codes never reach here as results)
            default:  y = a + b;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic, 1 bit/cycle shifts, valid/ready on both sides.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    seq_alu_state_e state_q, state_d;
    alu_op_e        op_q, op_d;
    logic [XLEN-1:0]    acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               zero_q, zero_d;

    alu_op_e            op_in;
    logic [SHAMT_W-1:0] shamt_in;
    logic [XLEN-1:0]    core_y;
    logic [XLEN-1:0]    acc_shift;
    logic               accept;
    logic               last_shift;

    assign op_in      = alu_op_e'(alu_ctrl);
    assign shamt_in   = op_b[SHAMT_W-1:0];
    assign accept     = (state_q == IDLE) && in_valid;
    assign last_shift = (state_q == SHIFT) && (cnt_q == SHAMT_W'(1));

    alu_core #(
        .XLEN (XLEN)
    ) u_alu_core (
        .op (alu_ctrl),
        .a  (op_a),
        .b  (op_b),
        .y  (core_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (is_shift(op_in) && (shamt_in != '0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        acc_shift = acc_q;
        case (op_q)
            ALU_SLL: acc_shift = {acc_q[XLEN-2:0], 1'b0};
            ALU_SRL: acc_shift = {1'b0, acc_q[XLEN-1:1]};
            ALU_SRA: acc_shift = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: acc_shift = acc_q;
        endcase
    end

    always_comb begin
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (accept) begin
            op_d  = op_in;
            acc_d = op_a;
            cnt_d = shamt_in;
            if (!is_shift(op_in)) begin
                result_d = core_y;
            end else if (shamt_in == '0) begin
                result_d = op_a;
            end
        end else if (state_q == SHIFT) begin
            acc_d = acc_shift;
            cnt_d = cnt_q - SHAMT_W'(1);
            if (last_shift) begin
                result_d = acc_shift;
            end
        end
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= ALU_ADD;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus randomized ops against a reference model.
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int vectors;
    int miscompares;

    seq_alu #(
        .XLEN (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] ctrl, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (ctrl)
            4'b1000: return a - b;
            4'b0001: return a << sh;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: return $signed(a) >>> sh;
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return a + b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] ctrl, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        if ((ctrl == 4'b0001 || ctrl == 4'b0101 || ctrl == 4'b1101) && sh != 0) return sh + 1;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Completes the result handshake and confirms the block is idle again.
    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ovalid_after"}, 32'(out_valid), 32'd0);
        check({tag, "_iready_after"}, 32'(in_ready), 32'd1);
    endtask

    // Issues one op and waits for its result; operands are scrambled right after accept.
    task automatic issue(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b);
        int          lat;
        logic [31:0] exp_r;
        exp_r = ref_alu(ctrl, a, b);
        @(negedge clk);
        check({tag, "_iready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        alu_ctrl = ctrl;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat <= 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(ref_lat(ctrl, b)));
        check({tag, "_result"}, result, exp_r);
        check({tag, "_zero"}, 32'(zero), 32'(exp_r == 32'd0));
    endtask

    initial begin
        logic [31:0] held;
        logic [3:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        alu_ctrl    = '0;
        op_a        = '0;
        op_b        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_iready", 32'(in_ready), 32'd1);
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        issue("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h1);
        release_result("add_ovf");
        issue("sub_zero", 4'b1000, 32'd5, 32'd5);
        release_result("sub_zero");
        issue("slt", 4'b0010, 32'hFFFF_FFFF, 32'd1);
        release_result("slt");
        issue("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1);
        release_result("sltu");
        issue("code_f", 4'b1111, 32'd3, 32'd4);
        release_result("code_f");
        issue("sra4", 4'b1101, 32'h8000_0000, 32'h24);
        release_result("sra4");
        issue("srl4", 4'b0101, 32'h8000_0000, 32'h24);
        release_result("srl4");
        issue("sll0", 4'b0001, 32'h1, 32'd0);
        release_result("sll0");
        issue("sll31", 4'b0001, 32'h1, 32'd31);
        release_result("sll31");

        // Backpressure: result must hold and a competing request must be ignored.
        issue("hold", 4'b0110, 32'h00F0_0000, 32'h0000_000F);
        held = result;
        in_valid = 1'b1;
        alu_ctrl = 4'b0000;
        op_a     = 32'd100;
        op_b     = 32'd200;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_result", result, 32'h00F0_000F);
            check("hold_iready", 32'(in_ready), 32'd0);
            check("hold_ovalid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        check("hold_same", result, held);
        release_result("hold");

        // Reset in the middle of a long shift aborts it without a result.
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = 4'b0001;
        op_a     = 32'h1;
        op_b     = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_iready", 32'(in_ready), 32'd1);
        check("abort_ovalid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_pulse", 32'(out_valid), 32'd0);
        end
        issue("post_rst_add", 4'b0000, 32'd2, 32'd3);
        release_result("post_rst_add");

        for (int n = 0; n < 40; n++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (n % 8 == 0) rb = 32'd0;
            if (n % 8 == 1) ra = rb;
            issue("rand", rc, ra, rb);
            release_result("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
